// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity mode
// constants, FSM state encodings and the 2-of-3 majority vote helper.
package uart_pkg;

  // Parity modes as selected by the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Receiver FSM state encodings
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_START  = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_PARITY = 3'd3;
  localparam state_t S_STOP   = 3'd4;
  localparam state_t S_BRK    = 3'd5;

  // 2-of-3 majority of the three mid-bit samples
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: a prescaler that divides clk by
// (baud_div_q + 1) and a per-bit oversample counter os_cnt (0..OVS-1).
// baud_div is captured on start so a frame always runs at one rate.
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int OVS   = 16,
  parameter int DIV_W = 16,
  parameter int OS_W  = $clog2(OVS)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             run,
  input  logic             start,
  input  logic [DIV_W-1:0] baud_div,
  output logic             os_tick,
  output logic [OS_W-1:0]  os_cnt
);

  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);

  logic [DIV_W-1:0] baud_div_q;
  logic [DIV_W-1:0] pre_cnt;

  assign os_tick = run && !start && (pre_cnt == baud_div_q);

  // Prescaler: latch the divisor at start, count while running, idle at 0
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      baud_div_q <= '0;
      pre_cnt    <= '0;
    end else if (start) begin
      baud_div_q <= baud_div;
      pre_cnt    <= '0;
    end else if (!run || (pre_cnt == baud_div_q)) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Oversample counter: advances once per tick and wraps at each bit end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      os_cnt <= '0;
    end else if (start || !run) begin
      os_cnt <= '0;
    end else if (os_tick) begin
      os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampled majority-vote bit recovery,
// 5-9 data bits, none/even/odd parity, 1 or 2 stop bits and a runtime
// baud divisor. Words leave on a valid/ready port with overrun reporting.
// Optional build macro UART_RX_BREAK_EN adds break detection (break_det
// output and a BRK state that waits for the line to return high).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16,
  parameter int DIV_W     = 16,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rx_en,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_BREAK_EN
  ,
  output logic                 break_det
`endif
);

  localparam int OS_W = $clog2(OVS);
  localparam logic [OS_W-1:0] OS_S0   = OS_W'(OVS / 2 - 1);
  localparam logic [OS_W-1:0] OS_S1   = OS_W'(OVS / 2);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVS / 2 + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);
  localparam logic [3:0]      BC_LAST = 4'(DATA_BITS - 1);
  localparam logic            SC_LAST = 1'(STOP_BITS - 1);
  localparam logic            ODD_SEL = (PARITY == PAR_ODD);

  logic rx_meta, rx_sync, rx_prev;
  logic fall;

  state_t state;
  logic tick_run, tick_start, os_tick;
  logic [OS_W-1:0] os_cnt;

  logic s0, s1, bit_val, mid, end_bit;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0] bit_cnt;
  logic stop_cnt;
  logic par_pend, frm_pend, frm_final;
  logic last_stop_mid, commit;

  // Two-flop synchroniser followed by the edge register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall       = rx_prev & ~rx_sync;
  assign tick_start = (state == S_IDLE) && rx_en && fall;
  assign tick_run   = (state == S_START) || (state == S_DATA) ||
                      (state == S_PARITY) || (state == S_STOP);
  assign busy       = (state != S_IDLE);

  uart_rx_tick_gen #(
    .OVS   (OVS),
    .DIV_W (DIV_W),
    .OS_W  (OS_W)
  ) u_tick (
    .clk      (clk),
    .arst_n   (arst_n),
    .run      (tick_run),
    .start    (tick_start),
    .baud_div (baud_div),
    .os_tick  (os_tick),
    .os_cnt   (os_cnt)
  );

  assign mid       = os_tick && (os_cnt == OS_MID);
  assign end_bit   = os_tick && (os_cnt == OS_LAST);
  assign bit_val   = maj3(s0, s1, rx_sync);
  assign frm_final = frm_pend | ~bit_val;
  assign last_stop_mid = (state == S_STOP) && mid && (stop_cnt == SC_LAST);

`ifdef UART_RX_BREAK_EN
  logic par_bit;
  logic is_break;
  assign is_break = (shreg == '0) && !par_bit && frm_final;
  assign commit   = last_stop_mid && !is_break;
`else
  assign commit   = last_stop_mid;
`endif

  // Capture the two early samples that feed the mid-bit majority vote
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else if (os_tick) begin
      if (os_cnt == OS_S0) s0 <= rx_sync;
      if (os_cnt == OS_S1) s1 <= rx_sync;
    end
  end

  // Frame FSM: start validation, data shift, parity and stop checking
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_pend <= 1'b0;
      frm_pend <= 1'b0;
`ifdef UART_RX_BREAK_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (tick_start) begin
            state    <= S_START;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_pend <= 1'b0;
            frm_pend <= 1'b0;
`ifdef UART_RX_BREAK_EN
            par_bit  <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (mid && bit_val) state <= S_IDLE;
          else if (end_bit)   state <= S_DATA;
        end
        S_DATA: begin
          if (mid) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (end_bit) begin
            if (bit_cnt == BC_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (mid) begin
            par_pend <= (^shreg) ^ bit_val ^ ODD_SEL;
`ifdef UART_RX_BREAK_EN
            par_bit  <= bit_val;
`endif
          end
          if (end_bit) state <= S_STOP;
        end
        S_STOP: begin
          if (mid) frm_pend <= frm_final;
          if (last_stop_mid) begin
`ifdef UART_RX_BREAK_EN
            state <= is_break ? S_BRK : S_IDLE;
`else
            state <= S_IDLE;
`endif
          end else if (end_bit) begin
            stop_cnt <= 1'b1;
          end
        end
`ifdef UART_RX_BREAK_EN
        S_BRK: begin
          if (rx_sync) state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output port: load a word on commit, drop valid on handshake
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      data_out   <= shreg;
      frame_err  <= frm_final;
      parity_err <= par_pend;
      data_valid <= 1'b1;
      overrun    <= data_valid & ~rd_ready;
    end else if (data_valid && rd_ready) begin
      data_valid <= 1'b0;
    end
  end

`ifdef UART_RX_BREAK_EN
  // One-cycle break pulse in place of a commit
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) break_det <= 1'b0;
    else         break_det <= last_stop_mid && is_break;
  end
`endif

endmodule
